// File: rtl/m10k_dump_pkg.sv
// rtl/m10k_dump_pkg.sv - shared types and constants for the M10K dump reader
package m10k_dump_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    FIN
  } state_t;

  localparam int CSUM_W = 16;

endpackage

// File: rtl/dump_fifo2.sv
// rtl/dump_fifo2.sv - two-entry FIFO with the head entry registered onto dout
module dump_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= din;
          else                 r_tail <= din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the incoming word lands wherever the new tail is.
          if (r_count == 2'd1) begin
            r_head <= din;
          end else begin
            r_head <= r_tail;
            r_tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = r_head;
  assign count = r_count;
  assign empty = (r_count == 2'd0);

endmodule

// File: rtl/m10k_dump_reader.sv
// rtl/m10k_dump_reader.sv - streams one M10K block onto a valid/ready channel
// DUMP_CHECKSUM_EN builds the running checksum; otherwise checksum is tied to 0.
module m10k_dump_reader
  import m10k_dump_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     START,
  input  logic signed [DATA_W-1:0] M10K_read_data,
  output logic        [ADDR_W-1:0] M10K_read_address_wire,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic signed [CSUM_W-1:0] checksum
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W:0]   r_issued;
  logic              r_inflight;

  logic [DATA_W-1:0] w_dout;
  logic [1:0]        w_count;
  logic              w_empty;
  logic              w_pop;
  logic              w_accept;
  logic [1:0]        w_occ;
  logic              w_issue;

  assign w_pop    = out_valid && out_ready;
  assign w_accept = (r_state == IDLE) && START;
  // Occupancy after this cycle's pop, so a steady stream can issue every cycle.
  assign w_occ    = w_count - {1'b0, w_pop};
  assign w_issue  = (r_state == SCAN) &&
                    (({1'b0, w_occ} + {2'b00, r_inflight}) < 3'd2) &&
                    (r_issued < DEPTH_C);

  dump_fifo2 #(.W(DATA_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_inflight),
    .din   (M10K_read_data),
    .pop   (w_pop),
    .dout  (w_dout),
    .count (w_count),
    .empty (w_empty)
  );

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE:  if (START) w_next = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (r_issued == DEPTH_C) w_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_empty && !r_inflight) w_next = FIN;
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rd_addr  <= BASE_C;
      r_issued   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_accept) begin
        r_rd_addr <= BASE_C;
        r_issued  <= '0;
      end else if (w_issue) begin
        r_rd_addr <= r_rd_addr + 1'b1;
        r_issued  <= r_issued + 1'b1;
      end
    end
  end

  assign M10K_read_address_wire = r_rd_addr;
  assign out_data               = w_dout;
  assign out_valid              = !w_empty;

`ifdef DUMP_CHECKSUM_EN
  logic signed [CSUM_W-1:0] r_csum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (w_pop) begin
      r_csum <= r_csum + CSUM_W'(out_data);
    end
  end

  assign checksum = r_csum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_m10k_dump_reader.sv
// tb/tb_m10k_dump_reader.sv - bench for m10k_dump_reader with three configurations
module tb_m10k_dump_reader;

  function automatic int dep_of(input int u);
    return (u == 0) ? 17 : ((u == 1) ? 256 : 1);
  endfunction

  function automatic int base_of(input int u);
    return (u == 2) ? 200 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s [3];
  logic        ready_s [3];
  logic [7:0]  addr_s  [3];
  logic [7:0]  data_s  [3];
  logic        valid_s [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic [15:0] csum_s  [3];
  logic [7:0]  mem     [3][256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] q;
    always @(posedge clk) q <= mem[g][addr_s[g]];

    m10k_dump_reader #(
      .DATA_W(8), .ADDR_W(8), .DEPTH(dep_of(g)), .BASE_ADDR(base_of(g))
    ) u_dut (
      .clk                    (clk),
      .reset                  (reset),
      .START                  (start_s[g]),
      .M10K_read_data         (q),
      .M10K_read_address_wire (addr_s[g]),
      .out_data               (data_s[g]),
      .out_valid              (valid_s[g]),
      .out_ready              (ready_s[g]),
      .busy                   (busy_s[g]),
      .done                   (done_s[g]),
      .checksum               (csum_s[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_scan(input int u, input int mode, input int start_at, input int rst_at);
    logic [7:0]  exp_q[$];
    logic [15:0] exp_sum = 16'd0;
    int          dep = dep_of(u);
    int          base = base_of(u);
    int          nb = 0, cyc = 0, rc = 0, first_v = -1, done_c = -1, done_n = 0, last_x = -1;
    logic        r = 1'b1;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_d = 8'd0;
    bit          pulsed = 1'b0;
    logic [15:0] csum_at_done = 16'd0;
    logic        busy_at_done = 1'b1;
    for (int i = 0; i < dep; i++) begin
      exp_q.push_back(mem[u][(base + i) % 256]);
      exp_sum += 16'($signed(mem[u][(base + i) % 256]));
    end
    chk("idle_busy", 32'(busy_s[u]), 32'd0);
    start_s[u] = 1'b1;
    @(posedge clk); #1;
    start_s[u] = 1'b0;
    chk("start_busy", 32'(busy_s[u]), 32'd1);
    chk("start_addr", 32'(addr_s[u]), 32'(base));
    while (cyc < 3000 && !(done_c >= 0 && cyc > done_c + 2)) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (rc % 4 == 0) || (rc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rc++;
      ready_s[u] = r;
      if (valid_s[u] && first_v < 0) first_v = cyc;
      if (prev_stall) begin
        chk("stall_valid", 32'(valid_s[u]), 32'd1);
        chk("stall_data", 32'(data_s[u]), 32'(prev_d));
      end
      if (done_s[u]) begin
        done_n++;
        if (done_c < 0) begin
          done_c       = cyc;
          csum_at_done = csum_s[u];
          busy_at_done = busy_s[u];
        end
      end
      if (valid_s[u] && r) begin
        if (nb < dep) chk("beat_data", 32'(data_s[u]), 32'(exp_q[nb]));
        else          chk("extra_beat", 32'(nb + 1), 32'(dep));
        nb++;
        last_x = cyc + 1;
      end
      start_s[u] = 1'b0;
      if (start_at >= 0 && nb == start_at && !pulsed) begin
        start_s[u] = 1'b1;
        pulsed     = 1'b1;
      end
      if (rst_at >= 0 && nb == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        ready_s[u] = 1'b1;
        chk("rst_valid", 32'(valid_s[u]), 32'd0);
        chk("rst_busy", 32'(busy_s[u]), 32'd0);
        chk("rst_done", 32'(done_s[u]), 32'd0);
        chk("rst_csum", 32'(csum_s[u]), 32'd0);
        chk("rst_addr", 32'(addr_s[u]), 32'(base));
        return;
      end
      prev_stall = valid_s[u] && !r;
      prev_d     = data_s[u];
      @(posedge clk); #1;
      cyc++;
    end
    ready_s[u] = 1'b1;
    start_s[u] = 1'b0;
    chk("beat_count", 32'(nb), 32'(dep));
    chk("done_count", 32'(done_n), 32'd1);
    chk("first_valid_lat", 32'(first_v), 32'd2);
    chk("done_lat", 32'(done_c), 32'(last_x + 1));
    chk("busy_at_done", 32'(busy_at_done), 32'd0);
`ifdef DUMP_CHECKSUM_EN
    chk("checksum", 32'(csum_at_done), 32'(exp_sum));
    chk("checksum_hold", 32'(csum_s[u]), 32'(exp_sum));
`else
    chk("checksum_tied", 32'(csum_at_done), 32'd0);
`endif
    chk("end_addr", 32'(addr_s[u]), 32'((base + dep) % 256));
    chk("end_busy", 32'(busy_s[u]), 32'd0);
    if (mode == 0) chk("stream_cycles", 32'(done_c), 32'(dep + 3));
  endtask

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      start_s[u] = 1'b0;
      ready_s[u] = 1'b1;
      for (int a = 0; a < 256; a++) mem[u][a] = 8'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk("reset_addr", 32'(addr_s[u]), 32'(base_of(u)));
      chk("reset_data", 32'(data_s[u]), 32'd0);
      chk("reset_valid", 32'(valid_s[u]), 32'd0);
      chk("reset_busy", 32'(busy_s[u]), 32'd0);
      chk("reset_done", 32'(done_s[u]), 32'd0);
      chk("reset_csum", 32'(csum_s[u]), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    for (int a = 0; a < 17; a++) mem[0][a] = 8'd1;
    run_scan(0, 0, -1, -1);

    for (int a = 0; a < 256; a++) mem[1][a] = 8'(a - 128);
    run_scan(1, 0, -1, -1);

    for (int a = 0; a < 17; a++) mem[0][a] = 8'(a);
    run_scan(0, 1, -1, -1);
    run_scan(0, 0, 5, -1);
    run_scan(0, 0, -1, 8);
    run_scan(0, 0, -1, -1);

    mem[2][200] = 8'hFB;
    run_scan(2, 0, -1, -1);

    for (int t = 0; t < 3; t++) begin
      for (int a = 0; a < 256; a++) mem[0][a] = 8'($urandom);
      run_scan(0, 2, -1, -1);
    end
    for (int a = 0; a < 256; a++) mem[1][a] = 8'($urandom);
    run_scan(1, 2, -1, -1);

    start_s[0] = 1'b1;
    reset      = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    reset      = 1'b0;
    chk("start_vs_reset_busy", 32'(busy_s[0]), 32'd0);
    @(posedge clk); #1;
    chk("start_not_queued", 32'(busy_s[0]), 32'd0);
    chk("start_not_queued_valid", 32'(valid_s[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
